// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product feed path: default geometry of a
// chunk (element width, elements per beat) and the streamer state encoding.
package dot_product_pkg;

   localparam int ELEMENT_WIDTH    = 32;
   localparam int NO_OF_UNITS      = 8;
   localparam int NO_OF_UNITS_LOG2 = $clog2(NO_OF_UNITS);

   // Streamer state encoding, kept as plain constants for legacy tooling.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_FETCH    = 3'd1;
   localparam state_t ST_LOAD     = 3'd2;
   localparam state_t ST_PRESENT  = 3'd3;
   localparam state_t ST_WAIT_FIN = 3'd4;
   localparam state_t ST_DONE     = 3'd5;

endpackage

// File: rtl/vector_pair_streamer_tail_mask.sv
// tail_mask: zeroes every element of a chunk whose index is at or above
// valid_count. Purely combinational; a full chunk passes with
// valid_count == no_of_units.
module tail_mask
   import dot_product_pkg::*;
#(
   parameter int element_width = ELEMENT_WIDTH,
   parameter int no_of_units   = NO_OF_UNITS,
   localparam int cnt_width    = $clog2(no_of_units) + 1
) (
   input  logic [element_width*no_of_units-1:0] chunk,
   input  logic [cnt_width-1:0]                 valid_count,
   output logic [element_width*no_of_units-1:0] masked
);

   // Keep elements below the valid count, force the rest to zero.
   always_comb begin
      masked = '0;
      for (int i = 0; i < no_of_units; i++) begin
         if (cnt_width'(i) < valid_count) begin
            masked[i*element_width +: element_width] = chunk[i*element_width +: element_width];
         end else begin
            masked[i*element_width +: element_width] = '0;
         end
      end
   end

endmodule

// File: rtl/vector_pair_streamer.sv
// vector_pair_streamer: fetches two operand vectors chunk by chunk from a pair
// of read ports, presents them beat by beat to a dot-product unit, waits for
// the unit's finish and captures its result.
// Optional build macro VPS_TAIL_MASK_EN: when defined, elements beyond
// `total` in the final beat are zeroed on both operand outputs; when
// undefined the final beat passes through untouched (storage must then hold
// zeros past the end of the vectors).
module vector_pair_streamer
   import dot_product_pkg::*;
#(
   parameter int element_width = ELEMENT_WIDTH,
   parameter int no_of_units   = NO_OF_UNITS,
   parameter int addr_width    = 10
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [31:0]                          total,
   output logic                                 rd_en,
   output logic [addr_width-1:0]                rd_addr,
   input  logic [element_width*no_of_units-1:0] rd_data_a,
   input  logic [element_width*no_of_units-1:0] rd_data_b,
   output logic [element_width*no_of_units-1:0] first_row_plus_additional,
   output logic [element_width*no_of_units-1:0] vector2,
   output logic                                 outsider_read_now,
   input  logic                                 I_am_ready,
   input  logic                                 finish,
   input  logic [element_width-1:0]             dot_product_output,
   output logic [element_width-1:0]             result,
   output logic                                 busy,
   output logic                                 done
);

   localparam int chunk_width = element_width * no_of_units;
   localparam int log2_units  = $clog2(no_of_units);
   localparam int cnt_width   = log2_units + 1;

`ifdef VPS_TAIL_MASK_EN
   localparam bit tail_mask_en = 1'b1;
`else
   localparam bit tail_mask_en = 1'b0;
`endif

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [31:0]             beats_r;
   logic [31:0]             idx_r;
   logic [31:0]             idx_nxt_s;
   logic [31:0]             beats_calc_s;
   logic [log2_units-1:0]   rem_r;
   logic                    last_beat_s;
   logic                    zero_run_s;
   logic [cnt_width-1:0]    valid_count_s;
   logic [chunk_width-1:0]  row_masked_s;
   logic [chunk_width-1:0]  vec_masked_s;
   logic [chunk_width-1:0]  row_r;
   logic [chunk_width-1:0]  vec_r;
   logic                    rd_en_r;
   logic [addr_width-1:0]   rd_addr_r;
   logic                    present_r;
   logic [element_width-1:0] result_r;
   logic                    busy_r;
   logic                    done_r;

   // Beat count: round total up to whole chunks (32-bit add wraps by design).
   always_comb begin
      beats_calc_s = (total + 32'(no_of_units - 1)) >> log2_units;
      zero_run_s   = (beats_calc_s == 32'd0);
   end

   // Next-state and beat-index logic.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               idx_nxt_s = 32'd0;
               if (zero_run_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH:   state_nxt_s = ST_LOAD;
         ST_LOAD:    state_nxt_s = ST_PRESENT;
         ST_PRESENT: begin
            if (I_am_ready) begin
               idx_nxt_s = idx_r + 32'd1;
               if (last_beat_s) begin
                  state_nxt_s = ST_WAIT_FIN;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         ST_WAIT_FIN: begin
            if (finish) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT_FIN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 32'd0;
         end
      endcase
   end

   // Valid-element count for the chunk being loaded; only a partial final
   // beat is trimmed, and only when tail masking is built in.
   always_comb begin
      last_beat_s = ((idx_r + 32'd1) == beats_r);
      if (tail_mask_en && last_beat_s && (rem_r != '0)) begin
         valid_count_s = {1'b0, rem_r};
      end else begin
         valid_count_s = cnt_width'(no_of_units);
      end
   end

   tail_mask #(
      .element_width (element_width),
      .no_of_units   (no_of_units)
   ) u_mask_row (
      .chunk       (rd_data_a),
      .valid_count (valid_count_s),
      .masked      (row_masked_s)
   );

   tail_mask #(
      .element_width (element_width),
      .no_of_units   (no_of_units)
   ) u_mask_vec (
      .chunk       (rd_data_b),
      .valid_count (valid_count_s),
      .masked      (vec_masked_s)
   );

   // State, beat index and the per-run parameters latched at start. Only the
   // remainder of total is needed once the beat count is known.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         idx_r   <= 32'd0;
         beats_r <= 32'd0;
         rem_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         if ((state_r == ST_IDLE) && start) begin
            beats_r <= beats_calc_s;
            rem_r   <= total[log2_units-1:0];
         end
      end
   end

   // Registered handshake and status outputs, derived from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_en_r   <= 1'b0;
         rd_addr_r <= '0;
         present_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         rd_en_r   <= (state_nxt_s == ST_FETCH);
         present_r <= (state_nxt_s == ST_PRESENT);
         busy_r    <= (state_nxt_s != ST_IDLE);
         done_r    <= (state_nxt_s == ST_DONE);
         if (state_nxt_s == ST_FETCH) begin
            rd_addr_r <= idx_nxt_s[addr_width-1:0];
         end
      end
   end

   // Beat data registers: loaded once per beat and held through PRESENT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_r <= '0;
         vec_r <= '0;
      end else if (state_r == ST_LOAD) begin
         row_r <= row_masked_s;
         vec_r <= vec_masked_s;
      end
   end

   // Result capture: consumer result on finish, zero for an empty run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_r <= '0;
      end else if ((state_r == ST_IDLE) && start && zero_run_s) begin
         result_r <= '0;
      end else if ((state_r == ST_WAIT_FIN) && finish) begin
         result_r <= dot_product_output;
      end
   end

   assign rd_en                     = rd_en_r;
   assign rd_addr                   = rd_addr_r;
   assign first_row_plus_additional = row_r;
   assign vector2                   = vec_r;
   assign outsider_read_now         = present_r;
   assign result                    = result_r;
   assign busy                      = busy_r;
   assign done                      = done_r;

endmodule

// File: tb/tb_vector_pair_streamer.sv
// Scoreboard bench for vector_pair_streamer: stimulus pushes expected read
// addresses, beats and results; a monitor pops and compares whenever the DUT
// presents them. Expected last-beat masking follows VPS_TAIL_MASK_EN.
module tb_vector_pair_streamer;

   localparam int EW = 32;
   localparam int NU = 8;
   localparam int AW = 10;
   localparam int CW = EW * NU;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   total;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data_a;
   logic [CW-1:0] rd_data_b;
   logic [CW-1:0] row_o;
   logic [CW-1:0] vec_o;
   logic          orn;
   logic          ready;
   logic          finish;
   logic [EW-1:0] dpo;
   logic [EW-1:0] result;
   logic          busy;
   logic          done;

   vector_pair_streamer #(.element_width(EW), .no_of_units(NU), .addr_width(AW)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .start                     (start),
      .total                     (total),
      .rd_en                     (rd_en),
      .rd_addr                   (rd_addr),
      .rd_data_a                 (rd_data_a),
      .rd_data_b                 (rd_data_b),
      .first_row_plus_additional (row_o),
      .vector2                   (vec_o),
      .outsider_read_now         (orn),
      .I_am_ready                (ready),
      .finish                    (finish),
      .dot_product_output        (dpo),
      .result                    (result),
      .busy                      (busy),
      .done                      (done)
   );

   always #5 clk = ~clk;

   // Operand storage: registered read, data one cycle after rd_en.
   logic [CW-1:0] mem_a [16];
   logic [CW-1:0] mem_b [16];

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= mem_a[rd_addr[3:0]];
         rd_data_b <= mem_b[rd_addr[3:0]];
      end
   end

   logic [AW-1:0] exp_addr [$];
   logic [CW-1:0] exp_row  [$];
   logic [CW-1:0] exp_vec  [$];
   logic [EW-1:0] exp_res  [$];

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_rd = 0, cnt_orn = 0, cnt_acc = 0, cnt_done = 0;
   int b_rd, b_orn, b_acc, b_done;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   task automatic fill_mem(input logic [31:0] base_a, input logic [31:0] base_b, input bit all_ones);
      for (int k = 0; k < 16; k++) begin
         for (int e = 0; e < NU; e++) begin
            mem_a[k][e*EW +: EW] = all_ones ? 32'hFFFF_FFFF : base_a + 32'(k*16 + e);
            mem_b[k][e*EW +: EW] = all_ones ? 32'hFFFF_FFFF : base_b + 32'(k*16 + e);
         end
      end
   endtask

   task automatic expect_beats(input int tot);
      int n;
      int rem;
      logic [CW-1:0] r;
      logic [CW-1:0] v;
      n   = (tot + NU - 1) / NU;
      rem = tot % NU;
      for (int b = 0; b < n; b++) begin
         r = mem_a[b];
         v = mem_b[b];
`ifdef VPS_TAIL_MASK_EN
         if ((b == n - 1) && (rem != 0)) begin
            for (int e = rem; e < NU; e++) begin
               r[e*EW +: EW] = 32'h0;
               v[e*EW +: EW] = 32'h0;
            end
         end
`endif
         exp_addr.push_back(AW'(b));
         exp_row.push_back(r);
         exp_vec.push_back(v);
      end
   endtask

   task automatic snap();
      b_rd = cnt_rd; b_orn = cnt_orn; b_acc = cnt_acc; b_done = cnt_done;
   endtask

   task automatic pulse_start(input int tot);
      @(posedge clk); #1;
      start = 1'b1;
      total = 32'(tot);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drained(input string name, input int budget);
      int i = 0;
      while ((exp_row.size() != 0) && (i < budget)) begin
         @(posedge clk); #1;
         i++;
      end
      if (exp_row.size() != 0) fail_now({name, " beats timeout"});
   endtask

   task automatic finish_with(input logic [EW-1:0] v);
      exp_res.push_back(v);
      @(posedge clk); #1;
      finish = 1'b1;
      dpo    = v;
      @(posedge clk); #1;
      finish = 1'b0;
      dpo    = 32'h0BAD_0BAD;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i = 0;
      while ((cnt_done == b_done) && (i < budget)) begin
         @(posedge clk); #1;
         i++;
      end
      if (cnt_done == b_done) fail_now({name, " done timeout"});
   endtask

   task automatic chk_counts(input string name, input int rd, input int acc, input int dn);
      chk({name, " rd_en count"}, CW'(cnt_rd - b_rd), CW'(rd));
      chk({name, " accept count"}, CW'(cnt_acc - b_acc), CW'(acc));
      chk({name, " done count"}, CW'(cnt_done - b_done), CW'(dn));
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " rd_en"}, CW'(rd_en), CW'(0));
      chk({name, " rd_addr"}, CW'(rd_addr), CW'(0));
      chk({name, " row"}, row_o, CW'(0));
      chk({name, " vector2"}, vec_o, CW'(0));
      chk({name, " outsider_read_now"}, CW'(orn), CW'(0));
      chk({name, " result"}, CW'(result), CW'(0));
      chk({name, " busy"}, CW'(busy), CW'(0));
      chk({name, " done"}, CW'(done), CW'(0));
   endtask

   task automatic normal_run(input string name, input int tot, input logic [EW-1:0] res);
      snap();
      expect_beats(tot);
      pulse_start(tot);
      wait_drained(name, 200);
      repeat (2) @(posedge clk);
      #1;
      finish_with(res);
      wait_done(name, 10);
      repeat (3) @(posedge clk);
      #1;
      chk({name, " busy after"}, CW'(busy), CW'(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; total = 32'd0; ready = 1'b0;
      finish = 1'b0; dpo = 32'h0;
      fork
         // Monitor: compares whatever the DUT presents against the queues.
         begin
            forever begin
               @(negedge clk);
               if (!reset) begin
                  if (rd_en) begin
                     cnt_rd++;
                     if (exp_addr.size() == 0) fail_now("unexpected rd_en");
                     else chk("rd_addr", CW'(rd_addr), CW'(exp_addr.pop_front()));
                  end
                  if (orn) begin
                     cnt_orn++;
                     if (exp_row.size() == 0) begin
                        fail_now("unexpected beat");
                     end else begin
                        chk("row beat", row_o, exp_row[0]);
                        chk("vector2 beat", vec_o, exp_vec[0]);
                        if (ready) begin
                           void'(exp_row.pop_front());
                           void'(exp_vec.pop_front());
                           cnt_acc++;
                        end
                     end
                  end
                  if (done) begin
                     cnt_done++;
                     if (exp_res.size() == 0) fail_now("unexpected done");
                     else chk("result", CW'(result), CW'(exp_res.pop_front()));
                  end
               end
            end
         end
         // Global watchdog.
         begin
            repeat (20000) @(posedge clk);
            fail_now("global timeout");
         end
         // Stimulus.
         begin
            repeat (3) @(posedge clk);
            #1;
            chk_all_zero("reset");
            reset = 1'b0;

            // Two full beats, consumer always ready.
            fill_mem(32'hA000_0000, 32'hB000_0000, 1'b0);
            ready = 1'b1;
            normal_run("t16", 16, 32'h0000_0064);
            chk_counts("t16", 2, 2, 1);
            chk("t16 result held", CW'(result), CW'(32'h64));

            // Partial final beat over all-ones storage.
            fill_mem(32'h0, 32'h0, 1'b1);
            normal_run("t11", 11, 32'h0000_1234);
            chk_counts("t11", 2, 2, 1);

            // Consumer stalls 5 cycles on the only beat.
            fill_mem(32'hC000_0000, 32'hD000_0000, 1'b0);
            ready = 1'b0;
            snap();
            expect_beats(8);
            pulse_start(8);
            for (int i = 0; i < 20 && !orn; i++) begin
               @(posedge clk); #1;
            end
            repeat (5) @(posedge clk);
            #1;
            ready = 1'b1;
            wait_drained("stall", 20);
            chk("stall valid cycles", CW'(cnt_orn - b_orn), CW'(6));
            repeat (1) @(posedge clk);
            #1;
            finish_with(32'h0000_00AA);
            wait_done("stall", 10);
            chk_counts("stall", 1, 1, 1);

            // Empty run: straight to DONE, result forced to zero.
            repeat (2) @(posedge clk);
            #1;
            snap();
            exp_res.push_back(32'h0);
            pulse_start(0);
            chk("t0 done pulse", CW'(done), CW'(1));
            @(posedge clk); #1;
            chk("t0 done low", CW'(done), CW'(0));
            chk("t0 busy", CW'(busy), CW'(0));
            chk("t0 result", CW'(result), CW'(0));
            chk("t0 valid count", CW'(cnt_orn - b_orn), CW'(0));
            chk_counts("t0", 0, 0, 1);

            // Reset while waiting for finish aborts the run silently.
            fill_mem(32'h1000_0000, 32'h2000_0000, 1'b0);
            snap();
            expect_beats(8);
            pulse_start(8);
            wait_drained("rst", 50);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            #1;
            chk_all_zero("mid reset");
            @(posedge clk); #1;
            finish = 1'b1;
            dpo    = 32'h0000_0077;
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            finish = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk_counts("rst", 1, 1, 0);
            chk("rst busy", CW'(busy), CW'(0));
            chk("rst result", CW'(result), CW'(0));
            normal_run("post rst", 8, 32'h0000_0321);
            chk("post rst result", CW'(result), CW'(32'h321));

            // Stray finish in FETCH and stray start in PRESENT are ignored.
            fill_mem(32'h3000_0000, 32'h4000_0000, 1'b0);
            snap();
            expect_beats(16);
            pulse_start(16);
            for (int i = 0; i < 10 && !rd_en; i++) begin
               @(posedge clk); #1;
            end
            finish = 1'b1;
            dpo    = 32'h0000_0999;
            @(posedge clk); #1;
            finish = 1'b0;
            for (int i = 0; i < 10 && !orn; i++) begin
               @(posedge clk); #1;
            end
            start = 1'b1;
            total = 32'd64;
            @(posedge clk); #1;
            start = 1'b0;
            wait_drained("ign", 50);
            repeat (2) @(posedge clk);
            #1;
            finish_with(32'h0000_0555);
            wait_done("ign", 10);
            repeat (6) @(posedge clk);
            #1;
            chk_counts("ign", 2, 2, 1);
            chk("ign result", CW'(result), CW'(32'h555));
            chk("ign busy", CW'(busy), CW'(0));
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
